// File: rtl/complex_mult_seq.sv
// rtl/complex_mult_seq.sv - time-multiplexed signed complex multiplier (one shared W x W multiplier)
//
// Computes p = a * b, or p = a * conj(b) when conj is set, by running the
// four partial products through one signed multiplier in four clock cycles.
// A new request is accepted in IDLE and also in M3, the final cycle of an
// operation, so a continuously held start produces one result every 4 cycles.
//
// Ports:
//   clk               system clock, rising edge
//   Reset             asynchronous, active-low reset
//   start             request, accepted only while busy is low
//   conj              1: multiply by the conjugate of b (latched with start)
//   a_re/a_im         operand a, signed W bits
//   b_re/b_im         operand b, signed W bits
//   busy              operands latched and partial products still pending
//   done              one-cycle pulse, p_re/p_im/ovf valid from this cycle
//   p_re/p_im         signed results, OUT_W bits each, held until next done
//   ovf               either component fell outside the signed OUT_W range

module complex_mult_seq #(
   parameter int W     = 4,
   parameter int OUT_W = 2*W+1,
   parameter bit SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             start,
   input  logic             conj,
   input  logic [W-1:0]     a_re,
   input  logic [W-1:0]     a_im,
   input  logic [W-1:0]     b_re,
   input  logic [W-1:0]     b_im,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] p_re,
   output logic [OUT_W-1:0] p_im,
   output logic             ovf
);

   localparam int AW = 2*W+1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_M0   = 3'd1,
      S_M1   = 3'd2,
      S_M2   = 3'd3,
      S_M3   = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic                 accept;
   logic signed [W-1:0]  ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
   logic                 conj_q, conj_d;
   logic signed [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic [OUT_W-1:0]     p_re_q, p_re_d, p_im_q, p_im_d;
   logic                 ovf_q, ovf_d;
   logic                 done_q, done_d;

   logic signed [W-1:0]   mul_x, mul_y;
   logic signed [2*W-1:0] prod;
   logic signed [AW-1:0]  prod_ext;
   logic signed [AW-1:0]  fin_re, fin_im;
   logic [OUT_W-1:0]      nar_re, nar_im;
   logic                  oor_re, oor_im;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_M0;
         S_M0:    state_d = S_M1;
         S_M1:    state_d = S_M2;
         S_M2:    state_d = S_M3;
         S_M3:    state_d = start ? S_M0 : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- outputs / multiplier operand select ----------------
   // M3 only needs the operands it latched earlier, so the latch is free to
   // take a new request on the same edge that retires the current one.
   always_comb begin
      busy   = (state_q == S_M0) || (state_q == S_M1) || (state_q == S_M2);
      accept = start && ((state_q == S_IDLE) || (state_q == S_M3));
      mul_x  = ar_q;
      mul_y  = br_q;
      case (state_q)
         S_M1:    begin mul_x = ai_q; mul_y = bi_q; end
         S_M2:    begin mul_x = ar_q; mul_y = bi_q; end
         S_M3:    begin mul_x = ai_q; mul_y = br_q; end
         default: begin mul_x = ar_q; mul_y = br_q; end
      endcase
   end

   // Operands are sign-extended first so the product is formed at full 2W width.
   assign prod     = (2*W)'(mul_x) * (2*W)'(mul_y);
   assign prod_ext = AW'(prod);

   assign fin_re = acc_re_q;
   assign fin_im = acc_im_q + prod_ext;

   // ---------------- result narrowing ----------------
   if (OUT_W >= AW) begin : g_wide
      assign nar_re = OUT_W'(fin_re);
      assign nar_im = OUT_W'(fin_im);
      assign oor_re = 1'b0;
      assign oor_im = 1'b0;
   end else begin : g_narrow
      localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
      localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
      logic [AW-OUT_W:0] top_re, top_im;

      // In range exactly when every bit from OUT_W-1 upward equals the sign.
      assign top_re = fin_re[AW-1:OUT_W-1];
      assign top_im = fin_im[AW-1:OUT_W-1];
      assign oor_re = !((&top_re) || !(|top_re));
      assign oor_im = !((&top_im) || !(|top_im));
      assign nar_re = (SAT && oor_re) ? (fin_re[AW-1] ? MIN_V : MAX_V) : fin_re[OUT_W-1:0];
      assign nar_im = (SAT && oor_im) ? (fin_im[AW-1] ? MIN_V : MAX_V) : fin_im[OUT_W-1:0];
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      ar_d     = ar_q;
      ai_d     = ai_q;
      br_d     = br_q;
      bi_d     = bi_q;
      conj_d   = conj_q;
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      p_re_d   = p_re_q;
      p_im_d   = p_im_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      case (state_q)
         S_M0: acc_re_d = acc_re_q + prod_ext;
         S_M1: acc_re_d = conj_q ? acc_re_q + prod_ext : acc_re_q - prod_ext;
         S_M2: acc_im_d = conj_q ? acc_im_q - prod_ext : acc_im_q + prod_ext;
         S_M3: begin
            acc_im_d = fin_im;
            p_re_d   = nar_re;
            p_im_d   = nar_im;
            ovf_d    = oor_re || oor_im;
            done_d   = 1'b1;
         end
         default: ;
      endcase
      if (accept) begin
         ar_d     = a_re;
         ai_d     = a_im;
         br_d     = b_re;
         bi_d     = b_im;
         conj_d   = conj;
         acc_re_d = '0;
         acc_im_d = '0;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         ar_q     <= '0;
         ai_q     <= '0;
         br_q     <= '0;
         bi_q     <= '0;
         conj_q   <= 1'b0;
         acc_re_q <= '0;
         acc_im_q <= '0;
         p_re_q   <= '0;
         p_im_q   <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         ar_q     <= ar_d;
         ai_q     <= ai_d;
         br_q     <= br_d;
         bi_q     <= bi_d;
         conj_q   <= conj_d;
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         p_re_q   <= p_re_d;
         p_im_q   <= p_im_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign done = done_q;
   assign p_re = p_re_q;
   assign p_im = p_im_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_complex_mult_seq.sv
// tb/tb_complex_mult_seq.sv - self-checking bench for complex_mult_seq (lossless, saturating, wrapping)

module tb_complex_mult_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       conj = 1'b0;
   logic [3:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

   logic       busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
   logic [8:0] p_re0, p_im0;
   logic [7:0] p_re1, p_im1, p_re2, p_im2;

   always #5 clk = ~clk;

   complex_mult_seq #(.W(4), .OUT_W(9), .SAT(1'b1)) dut0 (
      .clk(clk), .Reset(rst_n), .start(start), .conj(conj),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .busy(busy0), .done(done0), .p_re(p_re0), .p_im(p_im0), .ovf(ovf0));

   complex_mult_seq #(.W(4), .OUT_W(8), .SAT(1'b1)) dut1 (
      .clk(clk), .Reset(rst_n), .start(start), .conj(conj),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .busy(busy1), .done(done1), .p_re(p_re1), .p_im(p_im1), .ovf(ovf1));

   complex_mult_seq #(.W(4), .OUT_W(8), .SAT(1'b0)) dut2 (
      .clk(clk), .Reset(rst_n), .start(start), .conj(conj),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .busy(busy2), .done(done2), .p_re(p_re2), .p_im(p_im2), .ovf(ovf2));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks accepted requests by edge number: a request accepted at edge a
   // keeps busy high after edges a..a+2 and delivers its result after edge a+4.
   int cfg_w[3]   = '{9, 8, 8};
   bit cfg_sat[3] = '{1'b1, 1'b1, 1'b0};

   int edge_n     = 0;
   bit m_active   = 1'b0;
   int m_acc_edge = 0;
   int m_ar, m_ai, m_br, m_bi;
   bit m_cj;
   bit e_busy = 1'b0, e_done = 1'b0;
   int e_re[3], e_im[3];
   bit e_ovf[3];

   function automatic void narrow(input int v, input int ow, input bit sat,
                                  output int r, output bit oor);
      int lo, hi;
      lo  = -(1 << (ow - 1));
      hi  = (1 << (ow - 1)) - 1;
      oor = (v < lo) || (v > hi);
      if (!oor)     r = v;
      else if (sat) r = (v < lo) ? lo : hi;
      else          r = (v <<< (32 - ow)) >>> (32 - ow);
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e_re[i] = 0; e_im[i] = 0; e_ovf[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit busy_before;
      int re, im;
      bit o1, o2;
      if (!rst_n) return;
      busy_before = m_active && ((edge_n - m_acc_edge) <= 3);
      e_done = 1'b0;
      if (m_active && (edge_n - m_acc_edge) == 4) begin
         re = m_cj ? m_ar*m_br + m_ai*m_bi : m_ar*m_br - m_ai*m_bi;
         im = m_cj ? m_ai*m_br - m_ar*m_bi : m_ar*m_bi + m_ai*m_br;
         for (int i = 0; i < 3; i++) begin
            narrow(re, cfg_w[i], cfg_sat[i], e_re[i], o1);
            narrow(im, cfg_w[i], cfg_sat[i], e_im[i], o2);
            e_ovf[i] = o1 || o2;
         end
         e_done   = 1'b1;
         m_active = 1'b0;
      end
      if (start && !busy_before) begin
         m_ar = int'($signed(a_re)); m_ai = int'($signed(a_im));
         m_br = int'($signed(b_re)); m_bi = int'($signed(b_im));
         m_cj = conj;
         m_active   = 1'b1;
         m_acc_edge = edge_n;
      end
      e_busy = m_active && ((edge_n - m_acc_edge) <= 2);
      edge_n++;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      chk("busy0", busy0, e_busy);
      chk("busy1", busy1, e_busy);
      chk("busy2", busy2, e_busy);
      chk("done0", done0, e_done);
      chk("done1", done1, e_done);
      chk("done2", done2, e_done);
      chk("p_re0", int'($signed(p_re0)), e_re[0]);
      chk("p_im0", int'($signed(p_im0)), e_im[0]);
      chk("ovf0",  ovf0, e_ovf[0]);
      chk("p_re1", int'($signed(p_re1)), e_re[1]);
      chk("p_im1", int'($signed(p_im1)), e_im[1]);
      chk("ovf1",  ovf1, e_ovf[1]);
      chk("p_re2", int'($signed(p_re2)), e_re[2]);
      chk("p_im2", int'($signed(p_im2)), e_im[2]);
      chk("ovf2",  ovf2, e_ovf[2]);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_ops(input int ar, input int ai, input int br, input int bi, input bit cj);
      a_re = 4'(ar); a_im = 4'(ai); b_re = 4'(br); b_im = 4'(bi); conj = cj;
   endtask

   function automatic int rop();
      if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? -8 : 7;
      return int'($urandom_range(0, 15)) - 8;
   endfunction

   // Pulses start for one edge and counts edges until done; 0 means timeout.
   task automatic run_op(input int ar, input int ai, input int br, input int bi,
                         input bit cj, output int lat);
      set_ops(ar, ai, br, bi, cj);
      start = 1'b1;
      step();
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (done0) begin lat = i; break; end
      end
      if (lat == 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int lat, cnt, t_prev, n_done;
      int times[$];
      model_reset();
      step();
      step();
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_p_re", int'($signed(p_re0)), 0);
      chk("rst_ovf",  ovf0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1 / T2: lossless product and conjugate
      run_op(3, 2, 1, 4, 1'b0, lat);
      chk("t1_latency", lat, 4);
      chk("t1_p_re", int'($signed(p_re0)), -5);
      chk("t1_p_im", int'($signed(p_im0)), 14);
      chk("t1_ovf",  ovf0, 0);
      run_op(3, 2, 1, 4, 1'b1, lat);
      chk("t2_p_re", int'($signed(p_re0)), 11);
      chk("t2_p_im", int'($signed(p_im0)), -10);

      // T3: extreme operands, saturate and wrap at OUT_W=8
      run_op(-8, -8, -8, -8, 1'b0, lat);
      chk("t3_full_im", int'($signed(p_im0)), 128);
      chk("t3_full_ovf", ovf0, 0);
      chk("t3_sat_re", int'($signed(p_re1)), 0);
      chk("t3_sat_im", int'($signed(p_im1)), 127);
      chk("t3_sat_ovf", ovf1, 1);
      chk("t3_wrap_im", int'($signed(p_im2)), -128);
      chk("t3_wrap_ovf", ovf2, 1);

      // T4: start held for 12 edges, operands changing each cycle
      start = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (i == 12) start = 1'b0;
         set_ops(rop(), rop(), rop(), rop(), 1'($urandom_range(0, 1)));
         step();
         if (done0) times.push_back(i);
      end
      chk("t4_done_count", times.size(), 3);
      if (times.size() == 3) begin
         chk("t4_spacing_a", times[1] - times[0], 4);
         chk("t4_spacing_b", times[2] - times[1], 4);
      end

      // T5: second start while busy is ignored
      step();
      set_ops(1, -2, 3, -4, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      set_ops(7, 7, 7, 7, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done0) begin
            n_done++;
            chk("t5_p_re", int'($signed(p_re0)), -5);
            chk("t5_p_im", int'($signed(p_im0)), -10);
         end
      end
      chk("t5_done_count", n_done, 1);

      // T6: asynchronous reset while in M2
      set_ops(2, 3, -4, 5, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_busy", busy0, 0);
      chk("t6_done", done0, 0);
      chk("t6_p_re", int'($signed(p_re0)), 0);
      chk("t6_p_im", int'($signed(p_im0)), 0);
      chk("t6_ovf",  ovf1, 0);
      repeat (3) step();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done0) cnt++;
      end
      chk("t6_no_done", cnt, 0);

      // Randomized traffic with occasional mid-operation resets
      t_prev = 0;
      for (int i = 0; i < 400; i++) begin
         set_ops(rop(), rop(), rop(), rop(), 1'($urandom_range(0, 1)));
         start = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            model_reset();
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
         if (done0) t_prev++;
      end
      start = 1'b0;
      repeat (6) step();
      if (t_prev == 0) chk("rand_any_done", 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
